// File: rtl/key_event_generator.sv
// key_event_generator
//   Turns PS/2 set-2 scan-code bytes into one-cycle action strobes for the
//   game controller. It decodes E0/F0 prefixes, keeps a bitmap of held keys
//   so that typematic repeats from the keyboard are swallowed, and drives
//   key_drop_held as a level that follows the space bar.
//   Optional DAS/ARR auto-repeat for left/right/down is compiled in when the
//   macro KEY_AUTOREPEAT_EN is defined. Without it every press strobes once.
module key_event_generator #(
  parameter int DAS_CYCLES = 4_250_000,  // hold time before the first auto strobe
  parameter int ARR_CYCLES = 1_250_000   // spacing of later auto strobes
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       scancode_valid,
  input  logic       flush,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate_cw,
  output logic       key_rotate_ccw,
  output logic       key_drop,
  output logic       key_hold,
  output logic       key_drop_held
);

  // Bit positions in the held / strobe vectors. The movement keys come first
  // so the auto-repeat slice is simply bits [NMOVE-1:0].
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_DOWN  = 2;
  localparam int K_CW    = 3;
  localparam int K_CCW   = 4;
  localparam int K_DROP  = 5;
  localparam int K_HOLD  = 6;
  localparam int NKEYS   = 7;
  localparam int NMOVE   = 3;

  // Auto-repeat timing only makes sense for DAS >= 2, 1 <= ARR <= DAS.
  localparam bit CFG_OK = (DAS_CYCLES >= 2) && (ARR_CYCLES >= 1) &&
                          (ARR_CYCLES <= DAS_CYCLES);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  state_e             state_q, state_d;
  logic               make_evt;    // this byte completes a make code
  logic               brk_evt;     // this byte completes a break code
  logic               ext_code;    // the completed code carried an E0 prefix
  logic [NKEYS-1:0]   key_hit;     // one-hot map of the completed code
  logic [NKEYS-1:0]   make_vec;
  logic [NKEYS-1:0]   brk_vec;
  logic [NKEYS-1:0]   make_strobe; // first make of a key that was not held
  logic [NKEYS-1:0]   held_q, held_d;
  logic [NKEYS-1:0]   strobe_q, strobe_d;
  logic [NMOVE-1:0]   auto_vec;    // auto-repeat strobes for movement keys

  // Prefix FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prefix FSM next state; flags the byte that completes a make or break.
  always_comb begin
    state_d  = state_q;
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    ext_code = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else if (scancode_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (scancode == CODE_EXT) begin
            state_d = S_EXT;
          end else if (scancode == CODE_BRK) begin
            state_d = S_BRK;
          end else begin
            make_evt = 1'b1;
          end
        end
        S_EXT: begin
          if (scancode == CODE_BRK) begin
            state_d = S_EXT_BRK;
          end else if (scancode == CODE_EXT) begin
            state_d = S_EXT;  // repeated E0 keeps the extended context
          end else begin
            make_evt = 1'b1;
            ext_code = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          brk_evt = 1'b1;
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          brk_evt  = 1'b1;
          ext_code = 1'b1;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Code-to-key map. Plain and extended tables are disjoint, so plain 6B
  // (keypad 4) and anything else unlisted, including E1, map to nothing.
  always_comb begin
    key_hit = '0;
    if (ext_code) begin
      unique case (scancode)
        8'h6B:   key_hit[K_LEFT]  = 1'b1;
        8'h74:   key_hit[K_RIGHT] = 1'b1;
        8'h72:   key_hit[K_DOWN]  = 1'b1;
        8'h75:   key_hit[K_CW]    = 1'b1;
        default: key_hit = '0;
      endcase
    end else begin
      unique case (scancode)
        8'h1A:   key_hit[K_CCW]   = 1'b1;
        8'h29:   key_hit[K_DROP]  = 1'b1;
        8'h21:   key_hit[K_HOLD]  = 1'b1;
        default: key_hit = '0;
      endcase
    end
  end

  // A make on an already-held key is a typematic repeat and is dropped.
  assign make_vec    = make_evt ? key_hit : '0;
  assign brk_vec     = brk_evt  ? key_hit : '0;
  assign make_strobe = make_vec & ~held_q;

  // Held bitmap and strobe vector next state; flush clears everything.
  always_comb begin
    held_d   = (held_q | make_vec) & ~brk_vec;
    strobe_d = make_strobe;
    strobe_d[NMOVE-1:0] = make_strobe[NMOVE-1:0] | auto_vec;
    if (flush) begin
      held_d   = '0;
      strobe_d = '0;
    end
  end

  // Held bitmap and output strobe registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q   <= '0;
      strobe_q <= '0;
    end else begin
      held_q   <= held_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  if (CFG_OK) begin : g_auto
    // The counter reads 0 in the cycle the make strobe is visible and
    // advances once per held cycle, so a fire decision taken when it reads
    // DAS-1 lands the strobe exactly DAS cycles after the make strobe.
    // Reloading to DAS-ARR spaces later strobes ARR cycles apart, and the
    // counter never exceeds DAS-1, so it cannot wrap.
    localparam int            CW         = $clog2(DAS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DAS_CYCLES - 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DAS_CYCLES - ARR_CYCLES);

    for (genvar gi = 0; gi < NMOVE; gi++) begin : g_key
      logic [CW-1:0] cnt_q, cnt_d;
      logic          fire;

      // Per-key DAS/ARR counter; a break or flush in the firing cycle wins.
      always_comb begin
        cnt_d = cnt_q;
        fire  = 1'b0;
        if (flush || brk_vec[gi] || make_strobe[gi]) begin
          cnt_d = '0;
        end else if (held_q[gi]) begin
          if (cnt_q == CNT_LAST) begin
            fire  = 1'b1;
            cnt_d = CNT_RELOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Per-key counter register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign auto_vec[gi] = fire;
    end
  end else begin : g_auto_badcfg
    // Out-of-range timing parameters leave auto-repeat off.
    assign auto_vec = '0;
  end
`else
  // Auto-repeat is not built; the timing parameters are still range-checked
  // so both builds accept the same overrides.
  if (CFG_OK) begin : g_auto_off
    assign auto_vec = '0;
  end else begin : g_auto_off_badcfg
    assign auto_vec = '0;
  end
`endif

  assign key_left       = strobe_q[K_LEFT];
  assign key_right      = strobe_q[K_RIGHT];
  assign key_down       = strobe_q[K_DOWN];
  assign key_rotate_cw  = strobe_q[K_CW];
  assign key_rotate_ccw = strobe_q[K_CCW];
  assign key_drop       = strobe_q[K_DROP];
  assign key_hold       = strobe_q[K_HOLD];
  assign key_drop_held  = held_q[K_DROP];

endmodule

// File: tb/tb_key_event_generator.sv
// tb_key_event_generator
//   Directed bench for key_event_generator with DAS=10, ARR=4. A table of
//   one-cycle vectors covers decode, typematic suppression and flush; hand
//   sequences cover auto-repeat timing and asynchronous reset. Expectations
//   follow KEY_AUTOREPEAT_EN when the bench is built with that macro.
module tb_key_event_generator;

  localparam int DAS = 10;
  localparam int ARR = 4;

  // Strobe vector bits: {hold, drop, ccw, cw, down, right, left}
  localparam logic [6:0] S_0   = 7'h00;
  localparam logic [6:0] S_L   = 7'h01;
  localparam logic [6:0] S_R   = 7'h02;
  localparam logic [6:0] S_D   = 7'h04;
  localparam logic [6:0] S_CW  = 7'h08;
  localparam logic [6:0] S_CCW = 7'h10;
  localparam logic [6:0] S_DR  = 7'h20;
  localparam logic [6:0] S_H   = 7'h40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       flush;
  logic       key_left, key_right, key_down, key_rotate_cw;
  logic       key_rotate_ccw, key_drop, key_hold, key_drop_held;
  logic [6:0] str_vec;

  key_event_generator #(
    .DAS_CYCLES(DAS),
    .ARR_CYCLES(ARR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .flush          (flush),
    .key_left       (key_left),
    .key_right      (key_right),
    .key_down       (key_down),
    .key_rotate_cw  (key_rotate_cw),
    .key_rotate_ccw (key_rotate_ccw),
    .key_drop       (key_drop),
    .key_hold       (key_hold),
    .key_drop_held  (key_drop_held)
  );

  always #5 clk = ~clk;

  assign str_vec = {key_hold, key_drop, key_rotate_ccw, key_rotate_cw,
                    key_down, key_right, key_left};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       fl;
    logic       vld;
    logic [7:0] code;
    logic [6:0] str;
    logic       held;
  } vec_t;

  vec_t tbl[$];

  // Scheduled bytes / expected strobes for multi-cycle sequences, by offset
  // from the initial make strobe.
  logic       sq_v[0:63];
  logic [7:0] sq_c[0:63];
  logic [6:0] sq_e[0:63];

  function automatic vec_t mk(input logic fl, input logic vld, input logic [7:0] code,
                              input logic [6:0] str, input logic held);
    vec_t v;
    v.fl   = fl;
    v.vld  = vld;
    v.code = code;
    v.str  = str;
    v.held = held;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // One byte in one cycle, then compare {held, strobes} after the edge.
  task automatic send_byte(input logic [7:0] code, input string name,
                           input logic [6:0] exp_str, input logic exp_held);
    scancode_valid = 1'b1;
    scancode       = code;
    @(posedge clk);
    #1;
    scancode_valid = 1'b0;
    $display("byte %02h -> strobes %02h held %0b (%s)", code, str_vec, key_drop_held, name);
    check(name, {key_drop_held, str_vec}, {exp_held, exp_str});
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 64; i++) begin
      sq_v[i] = 1'b0;
      sq_c[i] = 8'h00;
      sq_e[i] = S_0;
    end
  endtask

  task automatic put(input int n, input logic [7:0] c);
    sq_v[n] = 1'b1;
    sq_c[n] = c;
  endtask

  task automatic run_seq(input string nm, input int len);
    for (int n = 1; n <= len; n++) begin
      scancode_valid = sq_v[n];
      scancode       = sq_c[n];
      @(posedge clk);
      #1;
      scancode_valid = 1'b0;
      if (sq_v[n] || sq_e[n] != S_0 || str_vec != S_0)
        $display("%s @%0d: byte %02h v%0b -> strobes %02h", nm, n, sq_c[n], sq_v[n], str_vec);
      check($sformatf("%s@%0d", nm, n), {1'b0, str_vec}, {1'b0, sq_e[n]});
    end
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    scancode_valid = 1'b0;
    scancode       = 8'h00;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {key_drop_held, str_vec}, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_idle", {key_drop_held, str_vec}, 8'h00);

    // ---------------- table-driven vectors ----------------
    tbl.push_back(mk(0, 1, 8'h29, S_DR,  1));  // space make
    tbl.push_back(mk(0, 0, 8'h00, S_0,   1));  // strobe is one cycle only
    tbl.push_back(mk(0, 1, 8'h29, S_0,   1));  // typematic repeat
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   1));
    tbl.push_back(mk(0, 1, 8'h29, S_0,   0));  // space break
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h29, S_0,   0));  // break of released key
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h6B, S_L,   0));  // left make
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h6B, S_0,   0));  // left typematic
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h6B, S_0,   0));  // left break
    tbl.push_back(mk(0, 1, 8'h6B, S_0,   0));  // plain 6B = keypad 4
    tbl.push_back(mk(0, 1, 8'h1C, S_0,   0));  // 'A' unmapped
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h1C, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hE1, S_0,   0));  // E1 unmapped
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h75, S_CW,  0));  // up arrow
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h75, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h1A, S_CCW, 0));  // 'Z'
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h72, S_D,   0));  // down arrow back-to-back
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h1A, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h72, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));  // double E0 stays extended
    tbl.push_back(mk(0, 1, 8'h74, S_R,   0));
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h74, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h29, S_DR,  1));  // space held again
    tbl.push_back(mk(1, 1, 8'h21, S_0,   0));  // flush beats the byte
    tbl.push_back(mk(0, 1, 8'h21, S_H,   0));  // 'C'
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h21, S_0,   0));
    tbl.push_back(mk(0, 1, 8'hE0, S_0,   0));
    tbl.push_back(mk(1, 0, 8'h00, S_0,   0));  // flush drops the E0 prefix
    tbl.push_back(mk(0, 1, 8'h29, S_DR,  1));  // decoded as plain
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   1));
    tbl.push_back(mk(0, 1, 8'h29, S_0,   0));
    tbl.push_back(mk(0, 1, 8'h29, S_DR,  1));  // new press strobes again
    tbl.push_back(mk(0, 1, 8'hF0, S_0,   1));
    tbl.push_back(mk(0, 1, 8'h29, S_0,   0));

    for (int i = 0; i < tbl.size(); i++) begin
      flush          = tbl[i].fl;
      scancode_valid = tbl[i].vld;
      scancode       = tbl[i].code;
      @(posedge clk);
      #1;
      flush          = 1'b0;
      scancode_valid = 1'b0;
      $display("vec %0d: flush %0b valid %0b byte %02h -> strobes %02h held %0b",
               i, tbl[i].fl, tbl[i].vld, tbl[i].code, str_vec, key_drop_held);
      check($sformatf("vec%0d", i), {key_drop_held, str_vec}, {tbl[i].held, tbl[i].str});
    end

    // ---------------- right arrow held: DAS/ARR timing ----------------
    // Break byte lands in the very cycle the next repeat would fire.
    send_byte(8'hE0, "rep_r_pre", S_0, 1'b0);
    send_byte(8'h74, "rep_r_make", S_R, 1'b0);
    clear_seq();
    put(20, 8'hE0);
    put(21, 8'hF0);
    put(22, 8'h74);
`ifdef KEY_AUTOREPEAT_EN
    sq_e[10] = S_R;
    sq_e[14] = S_R;
    sq_e[18] = S_R;
`endif
    run_seq("rep_r", 40);

    // ---------------- left held, down pressed on a repeat cycle ----------------
    send_byte(8'hE0, "rep_l_pre", S_0, 1'b0);
    send_byte(8'h6B, "rep_l_make", S_L, 1'b0);
    clear_seq();
    put(9,  8'hE0);
    put(10, 8'h72);
    put(15, 8'hE0);
    put(16, 8'hF0);
    put(17, 8'h6B);
    put(18, 8'hE0);
    put(19, 8'hF0);
    put(20, 8'h72);
    sq_e[10] = S_D;
`ifdef KEY_AUTOREPEAT_EN
    sq_e[10] = S_D | S_L;
    sq_e[14] = S_L;
`endif
    run_seq("rep_ld", 40);

    // ---------------- asynchronous reset mid-sequence ----------------
    send_byte(8'h29, "arst_space", S_DR, 1'b1);
    send_byte(8'hE0, "arst_e0", S_0, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("arst_clears_async", {key_drop_held, str_vec}, 8'h00);
    #2 rst = 1'b0;
    send_byte(8'h21, "arst_plain_decode", S_H, 1'b0);
    send_byte(8'hF0, "arst_brk_pre", S_0, 1'b0);
    send_byte(8'h21, "arst_brk", S_0, 1'b0);
    send_byte(8'h21, "arst_repress", S_H, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
